// File: rtl/hwpe_ctrl_vfpu_package.sv
// Shared floating-point field widths and the result-pipeline stage record
// for the vector FPU multiplier front end.
package hwpe_ctrl_vfpu_package;

    localparam int unsigned FP_WIDTH              = 32;
    localparam int unsigned FP_EXP_WIDTH          = 8;
    localparam int unsigned FP_MANT_WIDTH         = 23;
    localparam int unsigned FP_EXP_PRENORM_WIDTH  = 10;
    localparam int unsigned FP_MANT_PRENORM_WIDTH = 48;
    // Wide enough for the largest supported requester count (8).
    localparam int unsigned VFPU_ID_WIDTH         = 3;

    typedef struct packed {
        logic                             valid;
        logic [VFPU_ID_WIDTH-1:0]         id;
        logic                             sign;
        logic [FP_EXP_PRENORM_WIDTH-1:0]  exp;
        logic [FP_MANT_PRENORM_WIDTH-1:0] mant;
    } vfpu_mult_stage_t;

    // Mantissa with the implied leading bit; denormals (exponent 0) get 0.
    function automatic logic [FP_MANT_WIDTH:0] fp_mant_ext(input logic [FP_WIDTH-1:0] op);
        return {(op[FP_WIDTH-2 -: FP_EXP_WIDTH] != {FP_EXP_WIDTH{1'b0}}), op[FP_MANT_WIDTH-1:0]};
    endfunction

endpackage

// File: rtl/vfpu_rr_arbiter.sv
// Round-robin requester selection: the search begins one past the last
// granted index and wraps, producing a one-hot grant plus its index.
module vfpu_rr_arbiter #(
    parameter  int unsigned NB_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NB_REQ)
) (
    input  logic [NB_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]  ptr_i,
    output logic [NB_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              valid_o
);

    logic [IDX_W-1:0] cand_s;
    logic             found_s;

    // First requesting index in the rotated order wins.
    always_comb begin
        grant_o = {NB_REQ{1'b0}};
        idx_o   = {IDX_W{1'b0}};
        valid_o = 1'b0;
        cand_s  = {IDX_W{1'b0}};
        found_s = 1'b0;
        for (int off = 1; off <= int'(NB_REQ); off++) begin
            cand_s          = IDX_W'((int'(ptr_i) + off) % int'(NB_REQ));
            found_s         = req_i[cand_s] & ~valid_o;
            grant_o[cand_s] = grant_o[cand_s] | found_s;
            idx_o           = found_s ? cand_s : idx_o;
            valid_o         = valid_o | found_s;
        end
    end

endmodule

// File: rtl/vfpu_mult_arb.sv
// Arbitrates several requesters onto one external FP multiplier and carries
// the prenormalised products through an in-order, stallable result pipeline.
module vfpu_mult_arb
    import hwpe_ctrl_vfpu_package::*;
#(
    parameter  int unsigned NB_REQ     = 4,
    parameter  int unsigned PIPE_DEPTH = 2,
    localparam int unsigned IDX_W      = $clog2(NB_REQ)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    input  logic                                    clear_i,
    input  logic [NB_REQ-1:0]                       req_valid_i,
    output logic [NB_REQ-1:0]                       req_ready_o,
    input  logic [NB_REQ-1:0][FP_WIDTH-1:0]         req_opa_i,
    input  logic [NB_REQ-1:0][FP_WIDTH-1:0]         req_opb_i,
    output logic                                    mul_signa_o,
    output logic                                    mul_signb_o,
    output logic [FP_EXP_WIDTH-1:0]                 mul_expa_o,
    output logic [FP_EXP_WIDTH-1:0]                 mul_expb_o,
    output logic [FP_MANT_WIDTH:0]                  mul_manta_o,
    output logic [FP_MANT_WIDTH:0]                  mul_mantb_o,
    output logic                                    mul_opready_o,
    input  logic                                    mul_sign_i,
    input  logic signed [FP_EXP_PRENORM_WIDTH-1:0]  mul_exp_i,
    input  logic [FP_MANT_PRENORM_WIDTH-1:0]        mul_mant_i,
    input  logic                                    mul_done_i,
    output logic                                    res_valid_o,
    output logic [IDX_W-1:0]                        res_id_o,
    output logic                                    res_sign_o,
    output logic signed [FP_EXP_PRENORM_WIDTH-1:0]  res_exp_o,
    output logic [FP_MANT_PRENORM_WIDTH-1:0]        res_mant_o,
    input  logic                                    res_ready_i,
    output logic                                    busy_o
);

    logic [IDX_W-1:0]  ptr_r;
    logic [NB_REQ-1:0] grant_s;
    logic [IDX_W-1:0]  grant_idx_s;
    logic              grant_valid_s;
    logic              stall_s;
    logic              transfer_s;
    logic              busy_s;
    logic [FP_WIDTH-1:0] opa_s;
    logic [FP_WIDTH-1:0] opb_s;
    vfpu_mult_stage_t  stage_in_s;
    vfpu_mult_stage_t  stage_r [PIPE_DEPTH];

    vfpu_rr_arbiter #(
        .NB_REQ (NB_REQ)
    ) i_arbiter (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_r),
        .grant_o (grant_s),
        .idx_o   (grant_idx_s),
        .valid_o (grant_valid_s)
    );

    assign stall_s = stage_r[PIPE_DEPTH-1].valid & ~res_ready_i;

    // Clear and reset both suppress the grant so no requester sees a phantom handshake.
    assign req_ready_o   = grant_s & {NB_REQ{grant_valid_s & ~stall_s & ~clear_i & ~rst_i}};
    assign transfer_s    = |(req_valid_i & req_ready_o);
    assign mul_opready_o = transfer_s;

    assign opa_s       = req_opa_i[grant_idx_s];
    assign opb_s       = req_opb_i[grant_idx_s];
    assign mul_signa_o = opa_s[FP_WIDTH-1];
    assign mul_signb_o = opb_s[FP_WIDTH-1];
    assign mul_expa_o  = opa_s[FP_WIDTH-2 -: FP_EXP_WIDTH];
    assign mul_expb_o  = opb_s[FP_WIDTH-2 -: FP_EXP_WIDTH];
    assign mul_manta_o = fp_mant_ext(opa_s);
    assign mul_mantb_o = fp_mant_ext(opb_s);

    assign stage_in_s.valid = mul_done_i;
    assign stage_in_s.id    = VFPU_ID_WIDTH'(grant_idx_s);
    assign stage_in_s.sign  = mul_sign_i;
    assign stage_in_s.exp   = mul_exp_i;
    assign stage_in_s.mant  = mul_mant_i;

    // Round-robin pointer: moves only on a completed transfer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_r <= IDX_W'(NB_REQ - 1);
        end else if (clear_i) begin
            ptr_r <= IDX_W'(NB_REQ - 1);
        end else if (transfer_s) begin
            ptr_r <= grant_idx_s;
        end
    end

    // Result pipeline: whole pipe advances together and freezes under stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
                stage_r[i] <= '0;
            end
        end else if (clear_i) begin
            for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
                stage_r[i] <= '0;
            end
        end else if (!stall_s) begin
            stage_r[0] <= stage_in_s;
            for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    // Busy whenever any stage holds a live operation.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
            busy_s = busy_s | stage_r[i].valid;
        end
    end

    assign busy_o      = busy_s;
    assign res_valid_o = stage_r[PIPE_DEPTH-1].valid;
    assign res_id_o    = stage_r[PIPE_DEPTH-1].id[IDX_W-1:0];
    assign res_sign_o  = stage_r[PIPE_DEPTH-1].sign;
    assign res_exp_o   = stage_r[PIPE_DEPTH-1].exp;
    assign res_mant_o  = stage_r[PIPE_DEPTH-1].mant;

endmodule

// File: tb/tb_vfpu_mult_arb.sv
// Directed bench for vfpu_mult_arb with a zero-latency multiplier model
// closing the mul_* loop; results are checked against hand-computed values.
module tb_vfpu_mult_arb;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic               clear_i = 1'b0;
    logic [3:0]         req_valid_i = 4'b0000;
    logic [3:0]         req_ready_o;
    logic [3:0][31:0]   req_opa_i = '0;
    logic [3:0][31:0]   req_opb_i = '0;
    logic               mul_signa_o, mul_signb_o;
    logic [7:0]         mul_expa_o, mul_expb_o;
    logic [23:0]        mul_manta_o, mul_mantb_o;
    logic               mul_opready_o;
    logic               mul_sign_i;
    logic signed [9:0]  mul_exp_i;
    logic [47:0]        mul_mant_i;
    logic               mul_done_i;
    logic               res_valid_o;
    logic [1:0]         res_id_o;
    logic               res_sign_o;
    logic signed [9:0]  res_exp_o;
    logic [47:0]        res_mant_o;
    logic               res_ready_i = 1'b1;
    logic               busy_o;

    int n_cmp = 0;
    int n_err = 0;

    vfpu_mult_arb #(.NB_REQ(4), .PIPE_DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_opa_i(req_opa_i), .req_opb_i(req_opb_i),
        .mul_signa_o(mul_signa_o), .mul_signb_o(mul_signb_o),
        .mul_expa_o(mul_expa_o), .mul_expb_o(mul_expb_o),
        .mul_manta_o(mul_manta_o), .mul_mantb_o(mul_mantb_o),
        .mul_opready_o(mul_opready_o),
        .mul_sign_i(mul_sign_i), .mul_exp_i(mul_exp_i),
        .mul_mant_i(mul_mant_i), .mul_done_i(mul_done_i),
        .res_valid_o(res_valid_o), .res_id_o(res_id_o), .res_sign_o(res_sign_o),
        .res_exp_o(res_exp_o), .res_mant_o(res_mant_o),
        .res_ready_i(res_ready_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // External multiplier stand-in: product available in the transfer cycle.
    always_comb begin
        mul_done_i = mul_opready_o;
        mul_sign_i = mul_signa_o ^ mul_signb_o;
        mul_exp_i  = $signed({2'b00, mul_expa_o}) + $signed({2'b00, mul_expb_o}) - 10'sd127;
        mul_mant_i = 48'(mul_manta_o) * 48'(mul_mantb_o);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        rst_i = 1'b1; clear_i = 1'b0; req_valid_i = 4'b0000; res_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Requester i multiplies 2^i by 1.0 so res_exp identifies the source.
    task automatic load_pow2_ops();
        for (int i = 0; i < 4; i++) begin
            req_opa_i[i] = {1'b0, 8'(127 + i), 23'h000000};
            req_opb_i[i] = 32'h3F80_0000;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; req_valid_i = 4'b1111;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready_o); end
        n_cmp++; if (res_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", res_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (res_mant_o !== 48'h0 || res_exp_o !== 10'sd0) begin n_err++; $display("FAIL reset_res_fields: got exp %0d mant %h want 0", res_exp_o, res_mant_o); end
        req_valid_i = 4'b0000;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        req_opa_i[0] = 32'h3FC0_0000; req_opb_i[0] = 32'h4000_0000; req_valid_i = 4'b0001;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0001 || mul_opready_o !== 1'b1) begin n_err++; $display("FAIL single_grant: got ready %b opready %b want 0001/1", req_ready_o, mul_opready_o); end
        n_cmp++; if (mul_expa_o !== 8'd127 || mul_manta_o !== 24'hC00000 || mul_expb_o !== 8'd128 || mul_mantb_o !== 24'h800000) begin
            n_err++; $display("FAIL single_operands: got %0d/%h %0d/%h want 127/c00000 128/800000", mul_expa_o, mul_manta_o, mul_expb_o, mul_mantb_o); end
        @(negedge clk_i);
        req_valid_i = 4'b0000;
        #1;
        n_cmp++; if (res_valid_o !== 1'b0 || busy_o !== 1'b1) begin n_err++; $display("FAIL single_lat1: got valid %b busy %b want 0/1", res_valid_o, busy_o); end
        @(negedge clk_i); #1;
        n_cmp++; if (res_valid_o !== 1'b1 || res_id_o !== 2'd0 || res_sign_o !== 1'b0) begin n_err++; $display("FAIL single_result: got valid %b id %0d sign %b want 1/0/0", res_valid_o, res_id_o, res_sign_o); end
        n_cmp++; if (res_exp_o !== 10'sd128 || res_mant_o !== 48'h6000_0000_0000) begin n_err++; $display("FAIL single_value: got exp %0d mant %h want 128/600000000000", res_exp_o, res_mant_o); end
        @(negedge clk_i); #1;
        n_cmp++; if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL single_drain: got valid %b busy %b want 0/0", res_valid_o, busy_o); end
    endtask

    task automatic test_denormal();
        @(negedge clk_i);
        req_opa_i[0] = 32'h0000_0001; req_opb_i[0] = 32'h3F80_0000; req_valid_i = 4'b0001;
        #1;
        n_cmp++; if (mul_manta_o !== 24'h000001 || mul_expa_o !== 8'd0) begin n_err++; $display("FAIL denormal_fields: got exp %0d mant %h want 0/000001", mul_expa_o, mul_manta_o); end
        #1;
        req_valid_i = 4'b0000;
        @(negedge clk_i); #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL withdrawn_request: got busy %b want 0", busy_o); end
    endtask

    task automatic test_round_robin();
        logic [3:0]        exp_rdy;
        logic [1:0]        exp_id;
        logic signed [9:0] exp_e;
        do_reset();
        load_pow2_ops();
        req_valid_i = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            n_cmp++; if (req_ready_o !== exp_rdy) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready_o, exp_rdy); end
            if (k >= 2) begin
                exp_id = 2'((k - 2) % 4);
                exp_e  = 10'(127 + ((k - 2) % 4));
                n_cmp++; if (res_valid_o !== 1'b1 || res_id_o !== exp_id || res_exp_o !== exp_e) begin
                    n_err++; $display("FAIL rr_result[%0d]: got valid %b id %0d exp %0d want 1/%0d/%0d", k, res_valid_o, res_id_o, res_exp_o, exp_id, exp_e); end
            end
            @(negedge clk_i);
        end
        req_valid_i = 4'b0000;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_stall();
        logic [1:0] exp_id;
        do_reset();
        load_pow2_ops();
        req_valid_i = 4'b1111;
        @(negedge clk_i);
        @(negedge clk_i);
        res_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            n_cmp++; if (req_ready_o !== 4'b0000 || mul_opready_o !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b/%b want 0000/0", s, req_ready_o, mul_opready_o); end
            n_cmp++; if (res_valid_o !== 1'b1 || res_id_o !== 2'd0 || res_exp_o !== 10'sd127) begin
                n_err++; $display("FAIL stall_hold[%0d]: got valid %b id %0d exp %0d want 1/0/127", s, res_valid_o, res_id_o, res_exp_o); end
            @(negedge clk_i);
        end
        res_ready_i = 1'b1;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0100) begin n_err++; $display("FAIL stall_resume_grant: got %b want 0100", req_ready_o); end
        for (int r = 0; r < 4; r++) begin
            exp_id = 2'(r);
            n_cmp++; if (res_valid_o !== 1'b1 || res_id_o !== exp_id) begin n_err++; $display("FAIL stall_order[%0d]: got valid %b id %0d want 1/%0d", r, res_valid_o, res_id_o, exp_id); end
            @(negedge clk_i); #1;
        end
        req_valid_i = 4'b0000;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_pow2_ops();
        req_valid_i = 4'b1111;
        @(negedge clk_i);
        @(negedge clk_i);
        req_valid_i = 4'b0000; rst_i = 1'b1;
        #1;
        n_cmp++; if (busy_o !== 1'b0 || res_valid_o !== 1'b0 || req_ready_o !== 4'b0000) begin
            n_err++; $display("FAIL midreset_flush: got busy %b valid %b ready %b want 0/0/0000", busy_o, res_valid_o, req_ready_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL midreset_ghost[%0d]: got valid %b busy %b want 0/0", c, res_valid_o, busy_o); end
            @(negedge clk_i);
        end
        req_valid_i = 4'b1111;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0001) begin n_err++; $display("FAIL midreset_first_grant: got %b want 0001", req_ready_o); end
        #1;
        req_valid_i = 4'b0000;
        @(negedge clk_i);
    endtask

    task automatic test_clear();
        do_reset();
        load_pow2_ops();
        req_valid_i = 4'b0001;
        @(negedge clk_i);
        req_valid_i = 4'b0100; clear_i = 1'b1;
        #1;
        n_cmp++; if (req_ready_o !== 4'b0000 || mul_opready_o !== 1'b0) begin n_err++; $display("FAIL clear_drop: got ready %b opready %b want 0000/0", req_ready_o, mul_opready_o); end
        @(negedge clk_i);
        clear_i = 1'b0; req_valid_i = 4'b0101;
        #1;
        n_cmp++; if (busy_o !== 1'b0 || res_valid_o !== 1'b0) begin n_err++; $display("FAIL clear_empty: got busy %b valid %b want 0/0", busy_o, res_valid_o); end
        n_cmp++; if (req_ready_o !== 4'b0001) begin n_err++; $display("FAIL clear_ptr: got %b want 0001", req_ready_o); end
        @(negedge clk_i);
        req_valid_i = 4'b0000;
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_single();
        test_denormal();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
